// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial add/subtract, DIGIT bits per cycle, LSB digit first
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic [WIDTH-1:0] ws;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [IW-1:0]    base;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] s_dig;
    logic             c_slice;
    logic             c_msb_in;
    logic             last;
    logic [WIDTH-1:0] ws_next;

    // One shared DIGIT-bit ripple slice; the working sum is patched at the current digit.
    always_comb begin
        base              = IW'(cnt) * IW'(DIGIT);
        a_dig             = wa[base +: DIGIT];
        b_dig             = wb[base +: DIGIT];
        {c_slice, s_dig}  = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT + 1)'(carry);
        c_msb_in          = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
        last              = (cnt == CW'(N - 1));
        ws_next           = ws;
        ws_next[base +: DIGIT] = s_dig;
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wa       <= '0;
            wb       <= '0;
            ws       <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + ~borrow_in.
                        wa    <= a;
                        wb    <= sub ? ~b : b;
                        carry <= c_in ^ sub;
                        ws    <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    ws    <= ws_next;
                    carry <= c_slice;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum      <= ws_next;
                        c_out    <= c_slice;
                        overflow <= c_msb_in ^ c_slice;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for digit_serial_adder across DIGIT 2/1/4/16
module tb_digit_serial_adder;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         c;
        logic         ov;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         start_v [4];
    logic         ready_v [4];
    logic         done_v  [4];
    logic [W-1:0] sum_v   [4];
    logic         c_out_v [4];
    logic         ov_v    [4];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vt[8];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            localparam int DG = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 16;
            digit_serial_adder #(.WIDTH(W), .DIGIT(DG)) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start_v[g]),
                .a        (a),
                .b        (b),
                .c_in     (c_in),
                .sub      (sub),
                .ready    (ready_v[g]),
                .done     (done_v[g]),
                .sum      (sum_v[g]),
                .c_out    (c_out_v[g]),
                .overflow (ov_v[g])
            );
        end
    endgenerate

    function automatic int lat_of(int i);
        case (i)
            0:       return 8;
            1:       return 16;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + (W + 1)'(mc ^ ms);
        e.sum = full[W-1:0];
        e.c   = full[W];
        e.ov  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic launch(int i, logic [W-1:0] ta, logic [W-1:0] tb_, logic tc, logic ts);
        int w = 0;
        @(negedge clk);
        while (!ready_v[i] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_start", 32'(ready_v[i]), 1);
        a = ta; b = tb_; c_in = tc; sub = ts;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1 start_v[i] = 1'b0;
    endtask

    task automatic await_done(int i, string name);
        int   lat = 0;
        exp_t e;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!done_v[i] && lat < 40);
        chk({name, "_latency"}, 32'(lat), 32'(lat_of(i)));
        if (sb.size() == 0) begin
            chk({name, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, "_sum"}, 32'(sum_v[i]), 32'(e.sum));
            chk({name, "_c_out"}, 32'(c_out_v[i]), 32'(e.c));
            chk({name, "_overflow"}, 32'(ov_v[i]), 32'(e.ov));
        end
        @(posedge clk);
        #1;
        chk({name, "_done_clear"}, 32'(done_v[i]), 0);
        chk({name, "_ready_back"}, 32'(ready_v[i]), 1);
    endtask

    initial begin
        logic [W-1:0] prev;
        int           dones;
        exp_t         e;

        vt[0] = '{16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vt[6] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_ready", 32'(ready_v[i]), 1);
            chk("reset_done", 32'(done_v[i]), 0);
            chk("reset_sum", 32'(sum_v[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on every DIGIT configuration.
        for (int i = 0; i < 4; i++) begin
            for (int v = 0; v < 8; v++) begin
                launch(i, vt[v].a, vt[v].b, vt[v].cin, vt[v].sub);
                sb.push_back('{vt[v].sum, vt[v].c, vt[v].ov});
                await_done(i, $sformatf("vec%0d_inst%0d", v, i));
            end
        end

        // Start and operand changes during RUN must not disturb the running operation.
        prev = sum_v[0];
        launch(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        sb.push_back('{16'h3333, 1'b0, 1'b0});
        dones = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 2) begin
                start_v[0] = 1'b1; a = 16'hFFFF; b = 16'h1234; sub = 1'b1;
            end
            if (cyc == 3) start_v[0] = 1'b0;
            if (cyc == 4) begin
                chk("hs_ready_low_in_run", 32'(ready_v[0]), 0);
                chk("hs_sum_held", 32'(sum_v[0]), 32'(prev));
            end
            if (done_v[0]) begin
                dones++;
                if (dones == 1) begin
                    chk("hs_latency", 32'(cyc), 8);
                    e = sb.pop_front();
                    chk("hs_sum", 32'(sum_v[0]), 32'(e.sum));
                    chk("hs_c_out", 32'(c_out_v[0]), 32'(e.c));
                    chk("hs_overflow", 32'(ov_v[0]), 32'(e.ov));
                end
            end
        end
        chk("hs_done_count", 32'(dones), 1);

        // Asynchronous reset mid-RUN abandons the operation.
        launch(0, 16'hABCD, 16'h1111, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mid_ready", 32'(ready_v[0]), 1);
        chk("rst_mid_done", 32'(done_v[0]), 0);
        chk("rst_mid_sum", 32'(sum_v[0]), 0);
        chk("rst_mid_c_out", 32'(c_out_v[0]), 0);
        chk("rst_mid_overflow", 32'(ov_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        chk("rst_mid_no_done", 32'(dones), 0);

        // Random sweep against the reference model for DIGIT = 1, 4, 16.
        for (int i = 1; i < 4; i++) begin
            for (int n = 0; n < 1000; n++) begin
                logic [W-1:0] ra;
                logic [W-1:0] rb;
                logic         rc;
                logic         rs;
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                launch(i, ra, rb, rc, rs);
                sb.push_back(model(ra, rb, rc, rs));
                await_done(i, $sformatf("rand_inst%0d", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
